// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D cache refill paths, the arbiter and the memory port.
//   slave  : arbiter view (takes requests and mem_data_out, drives grants/done/rdata/mem_*)
//   master : requester/memory view (the opposite directions)
interface mem_arbiter_if;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_done;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic [31:0]       d_rdata;

  // Element 0 is the most significant byte (bits 31:24).
  logic [31:0]       mem_addr;
  logic              mem_we;
  logic [0:3][7:0]   mem_data_in;
  logic [0:3][7:0]   mem_data_out;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    output i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
           mem_addr, mem_we, mem_data_in
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    input  i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
           mem_addr, mem_we, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared main-memory port.
// Port I (read-only instruction refill) and port D (data refill/write-back)
// are served one at a time; address, we and write data are held for the fixed
// memory latency, read data is captured at the end and a one-cycle done pulse
// is issued.
//   clk   : clock, all state changes on posedge
//   reset : asynchronous, active-low
//   bus   : mem_arbiter_if.slave (request/grant/done/rdata per port, memory port)
module mem_arbiter #(
  parameter int unsigned READ_LAT  = 4,
  parameter int unsigned WRITE_LAT = 5,
  parameter int unsigned CNT_W     = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  // Counter value seen on the cycle before the completing edge.
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_d;       // 1 = last grant went to D, 0 = to I

  logic             pick_d_c;
  logic             last_beat_c;

  // Round-robin pick: D wins alone, or on a tie when I was granted last.
  // A D write is the only case where mem_we is high, so it selects the latency.
  always_comb begin
    pick_d_c    = bus.d_req && (!bus.i_req || !last_d);
    last_beat_c = bus.mem_we ? (cnt == WR_LAST) : (cnt == RD_LAST);
  end

  // Sequencer with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      last_d          <= 1'b0;
      bus.i_gnt       <= 1'b0;
      bus.i_done      <= 1'b0;
      bus.i_rdata     <= '0;
      bus.d_gnt       <= 1'b0;
      bus.d_done      <= 1'b0;
      bus.d_rdata     <= '0;
      bus.mem_addr    <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_data_in <= '0;
    end else begin
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_d_c) begin
            state           <= BUSY_D;
            cnt             <= '0;
            last_d          <= 1'b1;
            bus.d_gnt       <= 1'b1;
            bus.mem_addr    <= bus.d_addr;
            bus.mem_we      <= bus.d_we;
            bus.mem_data_in <= bus.d_wdata;
          end else if (bus.i_req) begin
            state        <= BUSY_I;
            cnt          <= '0;
            last_d       <= 1'b0;
            bus.i_gnt    <= 1'b1;
            bus.mem_addr <= bus.i_addr;
            bus.mem_we   <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          cnt <= cnt + CNT_W'(1);
          if (last_beat_c) begin
            state      <= DONE;
            bus.i_gnt  <= 1'b0;
            bus.d_gnt  <= 1'b0;
            bus.mem_we <= 1'b0;
            if (state == BUSY_I) begin
              bus.i_done  <= 1'b1;
              bus.i_rdata <= bus.mem_data_out;
            end else begin
              bus.d_done <= 1'b1;
              // Writes leave the last read result untouched.
              if (!bus.mem_we) begin
                bus.d_rdata <= bus.mem_data_out;
              end
            end
          end
        end
        DONE: begin
          // Requests are not sampled here; the requester drops req this cycle.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction scoreboard and a
// latency-accurate memory model.
module tb_mem_arbiter;
  localparam int unsigned READ_LAT  = 4;
  localparam int unsigned WRITE_LAT = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .READ_LAT  (READ_LAT),
    .WRITE_LAT (WRITE_LAT),
    .CNT_W     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        sb[$];
  txn_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          grants = 0;
  int          d_dones = 0;
  int          last_g = 0;
  int          prev_g = 0;
  int          gcnt = 0;
  int          wecnt = 0;
  int          busy_cnt = 0;
  int          i_hold = 0;
  bit          active = 1'b0;
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A0F0F);
  endfunction

  function automatic txn_t mk(input logic is_d, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.is_d = is_d; t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: read data is valid only on the last cycle of a read.
  always @(posedge clk or negedge reset) begin
    if (!reset) busy_cnt <= 0;
    else if (bus.i_gnt | bus.d_gnt) busy_cnt <= busy_cnt + 1;
    else busy_cnt <= 0;
  end
  assign bus.mem_data_out = (busy_cnt == int'(READ_LAT) - 1) ? mem_word(bus.mem_addr)
                                                             : 32'hBAD0BAD0;

  // Monitor: grant/done bookkeeping against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      active      = 1'b0;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
    end else begin
      chk("gnt_overlap", 32'(bus.i_gnt & bus.d_gnt), 32'h0);
      chk("gnt_with_done", 32'((bus.i_gnt | bus.d_gnt) & (bus.i_done | bus.d_done)), 32'h0);
      chk("we_without_dgnt", 32'(bus.mem_we & ~bus.d_gnt), 32'h0);
      if ((bus.i_gnt | bus.d_gnt) && !active) begin
        grants++;
        prev_g = last_g;
        last_g = cyc;
        active = 1'b1;
        gcnt   = 0;
        wecnt  = 0;
        if (sb.size() == 0) begin
          chk("unexpected_grant", 32'(sb.size()), 32'h1);
        end else begin
          cur = sb[0];
          chk("grant_port", 32'(bus.d_gnt), 32'(cur.is_d));
          chk("grant_addr", bus.mem_addr, cur.addr);
          chk("grant_we", 32'(bus.mem_we), 32'(cur.we));
          if (cur.we) chk("grant_wdata", bus.mem_data_in, cur.wdata);
        end
      end
      if (active && (bus.i_gnt | bus.d_gnt)) begin
        gcnt++;
        if (bus.mem_we) wecnt++;
        chk("addr_stable", bus.mem_addr, cur.addr);
      end
      if (bus.i_done | bus.d_done) begin
        if (bus.d_done) d_dones++;
        chk("done_has_txn", 32'(active && sb.size() != 0), 32'h1);
        if (active && sb.size() != 0) begin
          chk("done_port", 32'(bus.d_done), 32'(cur.is_d));
          chk("gnt_cycles", 32'(gcnt), cur.we ? 32'(WRITE_LAT) : 32'(READ_LAT));
          chk("we_cycles", 32'(wecnt), cur.we ? 32'(WRITE_LAT) : 32'h0);
          if (!cur.is_d) exp_i_rdata = mem_word(cur.addr);
          else if (!cur.we) exp_d_rdata = mem_word(cur.addr);
          chk("i_rdata", bus.i_rdata, exp_i_rdata);
          chk("d_rdata", bus.d_rdata, exp_d_rdata);
          void'(sb.pop_front());
        end
        active = 1'b0;
      end
    end
  end

  // Requester behaviour: wait for n done pulses, dropping req in the done cycle.
  task automatic serve(input int n, input int budget);
    int seen = 0;
    int k = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      k++;
      if (bus.i_done) begin
        seen++;
        if (i_hold > 0) i_hold--;
        else bus.i_req = 1'b0;
      end
      if (bus.d_done) begin
        seen++;
        bus.d_req = 1'b0;
      end
    end
    chk("serve_done_count", 32'(seen), 32'(n));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int dd0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_i_gnt", 32'(bus.i_gnt), 32'h0);
    chk("rst_d_gnt", 32'(bus.d_gnt), 32'h0);
    chk("rst_done", 32'(bus.i_done | bus.d_done), 32'h0);
    chk("rst_i_rdata", bus.i_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_mem_data_in", bus.mem_data_in, 32'h0);

    // First tie after reset goes to D; I follows after the DONE/IDLE gap.
    reset = 1'b1;
    sb.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0));
    sb.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0));
    bus.i_addr = 32'h100; bus.d_addr = 32'h200; bus.d_we = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    serve(2, 40);
    chk("tie1_spacing", 32'(last_g - prev_g), 32'(READ_LAT + 2));

    // Single D write; d_rdata must keep the earlier read value.
    @(negedge clk);
    sb.push_back(mk(1'b1, 1'b1, 32'h2004, 32'h12345678));
    bus.d_we = 1'b1; bus.d_addr = 32'h2004; bus.d_wdata = 32'h12345678; bus.d_req = 1'b1;
    serve(1, 40);
    chk("dwr_d_rdata_kept", bus.d_rdata, mem_word(32'h200));

    // Last grant was D, so this tie goes to I.
    @(negedge clk);
    sb.push_back(mk(1'b0, 1'b0, 32'h300, 32'h0));
    sb.push_back(mk(1'b1, 1'b0, 32'h400, 32'h0));
    bus.i_addr = 32'h300; bus.d_addr = 32'h400; bus.d_we = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    serve(2, 40);

    // Single I read returning DEADBEEF.
    @(negedge clk);
    sb.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0));
    bus.i_addr = 32'h40; bus.i_req = 1'b1;
    serve(1, 30);
    chk("i_rdata_deadbeef", bus.i_rdata, 32'hDEADBEEF);

    // Back-to-back D reads, second req raised in the IDLE cycle after done.
    @(negedge clk);
    sb.push_back(mk(1'b1, 1'b0, 32'h500, 32'h0));
    bus.d_we = 1'b0; bus.d_addr = 32'h500; bus.d_req = 1'b1;
    serve(1, 30);
    @(negedge clk);
    sb.push_back(mk(1'b1, 1'b0, 32'h504, 32'h0));
    bus.d_addr = 32'h504; bus.d_req = 1'b1;
    serve(1, 30);
    chk("b2b_spacing", 32'(last_g - prev_g), 32'(READ_LAT + 2));

    // i_req held through i_done gets a second full transaction.
    @(negedge clk);
    g0 = grants;
    sb.push_back(mk(1'b0, 1'b0, 32'h600, 32'h0));
    sb.push_back(mk(1'b0, 1'b0, 32'h600, 32'h0));
    i_hold = 1;
    bus.i_addr = 32'h600; bus.i_req = 1'b1;
    serve(2, 60);
    chk("hold_grants", 32'(grants - g0), 32'h2);

    // Reset in the middle of a D write aborts it; pending I is served afterwards.
    @(negedge clk);
    sb.push_back(mk(1'b1, 1'b1, 32'h700, 32'hCAFEF00D));
    bus.d_we = 1'b1; bus.d_addr = 32'h700; bus.d_wdata = 32'hCAFEF00D; bus.d_req = 1'b1;
    for (int k = 0; k < 10 && !bus.d_gnt; k++) @(negedge clk);
    chk("abort_dgnt_seen", 32'(bus.d_gnt), 32'h1);
    repeat (2) @(negedge clk);
    chk("abort_we_before", 32'(bus.mem_we), 32'h1);
    bus.i_addr = 32'h800; bus.i_req = 1'b1;
    dd0 = d_dones;
    reset = 1'b0;
    #1;
    chk("abort_mem_we", 32'(bus.mem_we), 32'h0);
    chk("abort_d_gnt", 32'(bus.d_gnt), 32'h0);
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    sb.push_back(mk(1'b0, 1'b0, 32'h800, 32'h0));
    reset = 1'b1;
    serve(1, 30);
    chk("abort_no_d_done", 32'(d_dones - dd0), 32'h0);
    chk("abort_i_rdata", bus.i_rdata, mem_word(32'h800));
    chk("abort_d_rdata_rst", bus.d_rdata, 32'h0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
